// File: rtl/twiddle_mult64.sv
// Streaming twiddle multiplier for the 64-point radix-2^2 SDF FFT: frame counter,
// twiddle address generation, complex multiply with round-half-up and saturation.
module twiddle_mult64 #(
  parameter int WIDTH = 16,
  parameter int TW_FF = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic [5:0]       tw_addr,
  input  logic [15:0]      tw_re,
  input  logic [15:0]      tw_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  localparam int PW = WIDTH + 16;
  localparam int SW = WIDTH + 17;
  localparam logic signed [SW-1:0] RND     = SW'(16384);
  localparam logic signed [SW-1:0] SAT_MAX = SW'((longint'(1) << (WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  // sample counter and address generation
  logic [5:0] k_q, k_d;
  logic [1:0] m;
  logic [5:0] addr;

  always_comb begin
    case (k_q[5:4])
      2'd0:    m = 2'd0;
      2'd1:    m = 2'd2;
      2'd2:    m = 2'd1;
      default: m = 2'd3;
    endcase
    addr = {4'b0, m} * {2'b0, k_q[3:0]};
    k_d  = di_en ? k_q + 6'd1 : k_q;
  end

  // S1
  logic [5:0]       tw_addr_q, tw_addr_d;
  logic [WIDTH-1:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d;
  logic             s1_byp_q, s1_byp_d, s1_en_q, s1_en_d;

  always_comb begin
    tw_addr_d = tw_addr_q;
    s1_re_d   = s1_re_q;
    s1_im_d   = s1_im_q;
    s1_byp_d  = s1_byp_q;
    s1_en_d   = di_en;
    if (di_en) begin
      tw_addr_d = addr;
      s1_re_d   = di_re;
      s1_im_d   = di_im;
      s1_byp_d  = (addr == 6'd0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k_q       <= '0;
      tw_addr_q <= '0;
      s1_re_q   <= '0;
      s1_im_q   <= '0;
      s1_byp_q  <= 1'b0;
      s1_en_q   <= 1'b0;
    end else begin
      k_q       <= k_d;
      tw_addr_q <= tw_addr_d;
      s1_re_q   <= s1_re_d;
      s1_im_q   <= s1_im_d;
      s1_byp_q  <= s1_byp_d;
      s1_en_q   <= s1_en_d;
    end
  end

  assign tw_addr = tw_addr_q;

  // Delay line so the data lines up with the table's read latency
  logic [WIDTH-1:0] al_re, al_im;
  logic             al_byp, al_en;

  generate
    if (TW_FF == 0) begin : g_nodly
      assign al_re  = s1_re_q;
      assign al_im  = s1_im_q;
      assign al_byp = s1_byp_q;
      assign al_en  = s1_en_q;
    end else begin : g_dly
      logic [WIDTH-1:0] dl_re_q [TW_FF];
      logic [WIDTH-1:0] dl_re_d [TW_FF];
      logic [WIDTH-1:0] dl_im_q [TW_FF];
      logic [WIDTH-1:0] dl_im_d [TW_FF];
      logic [TW_FF-1:0] dl_byp_q, dl_byp_d, dl_en_q, dl_en_d;

      always_comb begin
        dl_re_d[0]  = s1_re_q;
        dl_im_d[0]  = s1_im_q;
        dl_byp_d[0] = s1_byp_q;
        dl_en_d[0]  = s1_en_q;
        for (int i = 1; i < TW_FF; i++) begin
          dl_re_d[i]  = dl_re_q[i-1];
          dl_im_d[i]  = dl_im_q[i-1];
          dl_byp_d[i] = dl_byp_q[i-1];
          dl_en_d[i]  = dl_en_q[i-1];
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < TW_FF; i++) begin
            dl_re_q[i] <= '0;
            dl_im_q[i] <= '0;
          end
          dl_byp_q <= '0;
          dl_en_q  <= '0;
        end else begin
          for (int i = 0; i < TW_FF; i++) begin
            dl_re_q[i] <= dl_re_d[i];
            dl_im_q[i] <= dl_im_d[i];
          end
          dl_byp_q <= dl_byp_d;
          dl_en_q  <= dl_en_d;
        end
      end

      assign al_re  = dl_re_q[TW_FF-1];
      assign al_im  = dl_im_q[TW_FF-1];
      assign al_byp = dl_byp_q[TW_FF-1];
      assign al_en  = dl_en_q[TW_FF-1];
    end
  endgenerate

  // S2: partial products, operands sign-extended to product width
  logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [PW-1:0] p_rr_q, p_rr_d, p_ii_q, p_ii_d, p_ri_q, p_ri_d, p_ir_q, p_ir_d;
  logic [WIDTH-1:0]     s2_re_q, s2_re_d, s2_im_q, s2_im_d;
  logic                 s2_byp_q, s2_byp_d, s2_en_q, s2_en_d;

  always_comb begin
    ar_x     = {{16{al_re[WIDTH-1]}}, al_re};
    ai_x     = {{16{al_im[WIDTH-1]}}, al_im};
    br_x     = {{WIDTH{tw_re[15]}}, tw_re};
    bi_x     = {{WIDTH{tw_im[15]}}, tw_im};
    p_rr_d   = p_rr_q;
    p_ii_d   = p_ii_q;
    p_ri_d   = p_ri_q;
    p_ir_d   = p_ir_q;
    s2_re_d  = s2_re_q;
    s2_im_d  = s2_im_q;
    s2_byp_d = s2_byp_q;
    s2_en_d  = al_en;
    if (al_en) begin
      p_rr_d   = ar_x * br_x;
      p_ii_d   = ai_x * bi_x;
      p_ri_d   = ar_x * bi_x;
      p_ir_d   = ai_x * br_x;
      s2_re_d  = al_re;
      s2_im_d  = al_im;
      s2_byp_d = al_byp;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_rr_q   <= '0;
      p_ii_q   <= '0;
      p_ri_q   <= '0;
      p_ir_q   <= '0;
      s2_re_q  <= '0;
      s2_im_q  <= '0;
      s2_byp_q <= 1'b0;
      s2_en_q  <= 1'b0;
    end else begin
      p_rr_q   <= p_rr_d;
      p_ii_q   <= p_ii_d;
      p_ri_q   <= p_ri_d;
      p_ir_q   <= p_ir_d;
      s2_re_q  <= s2_re_d;
      s2_im_q  <= s2_im_d;
      s2_byp_q <= s2_byp_d;
      s2_en_q  <= s2_en_d;
    end
  end

  // S3: full-width sum, round half up, saturate
  function automatic logic [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else                  return v[WIDTH-1:0];
  endfunction

  logic signed [SW-1:0] re_full, im_full, re_sh, im_sh;
  logic [WIDTH-1:0]     do_re_q, do_re_d, do_im_q, do_im_d;
  logic                 do_en_q, do_en_d;

  always_comb begin
    re_full = {p_rr_q[PW-1], p_rr_q} - {p_ii_q[PW-1], p_ii_q};
    im_full = {p_ri_q[PW-1], p_ri_q} + {p_ir_q[PW-1], p_ir_q};
    re_sh   = (re_full + RND) >>> 15;
    im_sh   = (im_full + RND) >>> 15;
    do_en_d = s2_en_q;
    do_re_d = do_re_q;
    do_im_d = do_im_q;
    if (s2_en_q) begin
      do_re_d = s2_byp_q ? s2_re_q : sat(re_sh);
      do_im_d = s2_byp_q ? s2_im_q : sat(im_sh);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      do_en_q <= 1'b0;
      do_re_q <= '0;
      do_im_q <= '0;
    end else begin
      do_en_q <= do_en_d;
      do_re_q <= do_re_d;
      do_im_q <= do_im_d;
    end
  end

  assign do_en = do_en_q;
  assign do_re = do_re_q;
  assign do_im = do_im_q;

endmodule

// File: tb/tb_twiddle_mult64.sv
// Randomized bench for twiddle_mult64 against a frame-level reference model
// and a behavioural twiddle table (exp(-j*2*pi*n/64), entry 0 held at zero).
module tb_twiddle_mult64;

  localparam int TB_TW_FF = 1;
  localparam int LAT      = 3 + TB_TW_FF;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        di_en;
  logic [15:0] di_re, di_im;
  logic [5:0]  tw_addr;
  logic [15:0] tw_re, tw_im;
  logic        do_en;
  logic [15:0] do_re, do_im;

  twiddle_mult64 #(.WIDTH(16), .TW_FF(TB_TW_FF)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .di_en   (di_en),
    .di_re   (di_re),
    .di_im   (di_im),
    .tw_addr (tw_addr),
    .tw_re   (tw_re),
    .tw_im   (tw_im),
    .do_en   (do_en),
    .do_re   (do_re),
    .do_im   (do_im)
  );

  always #5 clock = ~clock;

  logic signed [15:0] tab_re [64];
  logic signed [15:0] tab_im [64];

  function automatic int q15(input real x);
    real s;
    int  r;
    s = 32768.0 * x;
    r = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
    if (r > 32767) r = 32767;
    return r;
  endfunction

  initial begin
    for (int n = 0; n < 64; n++) begin
      if (n == 0) begin
        tab_re[n] = 16'sd0;
        tab_im[n] = 16'sd0;
      end else begin
        tab_re[n] = 16'(q15($cos(2.0 * 3.14159265358979 * n / 64.0)));
        tab_im[n] = 16'(q15(-$sin(2.0 * 3.14159265358979 * n / 64.0)));
      end
    end
  end

  generate
    if (TB_TW_FF == 0) begin : g_tab_comb
      always_comb begin
        tw_re = tab_re[tw_addr];
        tw_im = tab_im[tw_addr];
      end
    end else begin : g_tab_reg
      always @(posedge clock) begin
        tw_re <= tab_re[tw_addr];
        tw_im <= tab_im[tw_addr];
      end
    end
  endgenerate

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    int     due;
    longint re;
    longint im;
    int     k;
    int     dir;
  } exp_t;

  exp_t   expq[$];
  int     model_k  = 0;
  longint exp_addr = 0;
  int     mult_of_q [4] = '{0, 2, 1, 3};

  function automatic longint round_sat(input longint x);
    longint r;
    r = (x + 64'sd16384) >>> 15;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic check_outputs();
    bit   due_now;
    exp_t e;
    check_val("tw_addr", tw_addr, exp_addr);
    due_now = (expq.size() > 0) && (expq[0].due == cyc);
    check_val("do_en", do_en, due_now);
    if (due_now) begin
      e = expq.pop_front();
      if (do_en) begin
        check_val("do_re", $signed(do_re), e.re);
        check_val("do_im", $signed(do_im), e.im);
        if (e.dir == 1 && e.k == 16) begin
          check_val("const_k16_re", $signed(do_re), 16384);
          check_val("const_k16_im", $signed(do_im), 0);
        end
        if (e.dir == 1 && e.k == 24) begin
          check_val("const_k24_re", $signed(do_re), 0);
          check_val("const_k24_im", $signed(do_im), -16384);
        end
        if (e.dir == 1 && e.k == 17) begin
          check_val("const_k17_re", $signed(do_re), 16069);
          check_val("const_k17_im", $signed(do_im), -3196);
        end
        if (e.dir == 2 && e.k == 24) begin
          check_val("sat_re", $signed(do_re), -32768);
          check_val("sat_im", $signed(do_im), 32767);
        end
      end
    end
  endtask

  // Apply one cycle of input, update the model, then check mid-cycle.
  task automatic step(input bit en, input logic [15:0] re, input logic [15:0] im, input int dir);
    exp_t   e;
    longint ar, ai, br, bi;
    int     a;
    di_en = en;
    di_re = re;
    di_im = im;
    if (en) begin
      a  = mult_of_q[model_k / 16] * (model_k % 16);
      ar = longint'($signed(re));
      ai = longint'($signed(im));
      br = longint'(tab_re[a]);
      bi = longint'(tab_im[a]);
      e.due = cyc + LAT;
      e.k   = model_k;
      e.dir = dir;
      if (a == 0) begin
        e.re = ar;
        e.im = ai;
      end else begin
        e.re = round_sat(ar * br - ai * bi);
        e.im = round_sat(ar * bi + ai * br);
      end
      expq.push_back(e);
      exp_addr = a;
      model_k  = (model_k + 1) % 64;
    end
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      di_en = 1'($urandom());
      di_re = 16'($urandom());
      di_im = 16'($urandom());
      @(posedge clock);
      @(negedge clock);
      check_val("rst_tw_addr", tw_addr, 0);
      check_val("rst_do_en", do_en, 0);
      check_val("rst_do_re", do_re, 0);
      check_val("rst_do_im", do_im, 0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    di_en   = 1'b1;
    di_re   = 16'($urandom());
    di_im   = 16'($urandom());
    @(negedge clock);
    reset_cycles(4);
    reset_n = 1'b1;

    // two contiguous frames of random data
    for (int i = 0; i < 128; i++) step(1'b1, 16'($urandom()), 16'($urandom()), 0);

    // constant input (16384, 0)
    for (int i = 0; i < 64; i++) step(1'b1, 16'd16384, 16'd0, 1);

    // saturation at k=24
    for (int i = 0; i < 64; i++) begin
      if (model_k == 24) step(1'b1, 16'h8000, 16'h8000, 2);
      else               step(1'b1, 16'($urandom()), 16'($urandom()), 0);
    end

    // gapped 1,0,1,0
    for (int i = 0; i < 128; i++) step(i % 2 == 0, 16'($urandom()), 16'($urandom()), 0);

    // random enables
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 9) < 7, 16'($urandom()), 16'($urandom()), 0);

    // reset mid-frame right after sample 37
    for (int i = 0; i < 64 && model_k != 38; i++)
      step(1'b1, 16'($urandom()), 16'($urandom()), 0);
    reset_n = 1'b0;
    #1;
    check_val("async_tw_addr", tw_addr, 0);
    check_val("async_do_en", do_en, 0);
    check_val("async_do_re", do_re, 0);
    check_val("async_do_im", do_im, 0);
    expq.delete();
    model_k  = 0;
    exp_addr = 0;
    reset_cycles(3);
    reset_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) step(1'b0, 16'($urandom()), 16'($urandom()), 0);

    // fresh frame after reset, constant-input pass included
    for (int i = 0; i < 64; i++) step(1'b1, 16'd16384, 16'd0, 1);
    for (int i = 0; i < 64; i++) step(1'b1, 16'($urandom()), 16'($urandom()), 0);

    for (int i = 0; i < LAT + 2; i++) step(1'b0, 16'd0, 16'd0, 0);
    check_val("drain_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
